// File: rtl/board_io_conditioner.sv
// Board-level conditioning between FPGA pins and the game core: reset sequencing,
// button debounce with press/release pulses, and a divided clock mirror for a PMOD pin.
module board_io_conditioner #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 650000,
  parameter int RST_STRETCH     = 1024,
  parameter int MIRROR_HALF     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             locked_i,
  input  logic             rst_btn_i,
  input  logic [N_BTN-1:0] btn_i,
  output logic             sys_rst_o,
  output logic             ready_o,
  output logic [N_BTN-1:0] btn_level_o,
  output logic [N_BTN-1:0] btn_press_o,
  output logic [N_BTN-1:0] btn_release_o,
  output logic             mirror_o
);

  localparam int N_CH = N_BTN + 1;
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int ST_W = $clog2(RST_STRETCH + 1);
  localparam int MR_W = $clog2(MIRROR_HALF + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(RST_STRETCH - 1);
  localparam logic [MR_W-1:0] MR_LAST = MR_W'(MIRROR_HALF - 1);

  if (N_BTN < 1) begin : g_bad_n_btn
    $error("board_io_conditioner: N_BTN must be >= 1");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("board_io_conditioner: DEBOUNCE_CYCLES must be >= 2");
  end
  if (RST_STRETCH < 1) begin : g_bad_stretch
    $error("board_io_conditioner: RST_STRETCH must be >= 1");
  end
  if (MIRROR_HALF < 1) begin : g_bad_mirror
    $error("board_io_conditioner: MIRROR_HALF must be >= 1");
  end

  typedef enum logic [1:0] {
    HOLD,
    STRETCH,
    RUN
  } state_t;

  // Channel 0 is the reset button; channels 1..N_BTN are the general buttons.
  logic [N_CH-1:0] raw;
  logic [N_CH-1:0] meta;
  logic [N_CH-1:0] sync;
  logic            lock_meta;
  logic            lock_sync;

  assign raw = {btn_i, rst_btn_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta      <= '0;
      sync      <= '0;
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      meta      <= raw;
      sync      <= meta;
      lock_meta <= locked_i;
      lock_sync <= lock_meta;
    end
  end

  logic [N_CH-1:0] stable;
  logic [N_CH-1:0] fire;

  for (genvar g = 0; g < N_CH; g++) begin : g_db
    logic [DB_W-1:0] cnt;
    logic            st;

    assign fire[g]   = (sync[g] != st) && (cnt == DB_LAST);
    assign stable[g] = st;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
        st  <= 1'b0;
      end else if (sync[g] == st) begin
        cnt <= '0;
      end else if (fire[g]) begin
        st  <= sync[g];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  logic rst_btn_db;
  assign rst_btn_db  = stable[0];
  assign btn_level_o = stable[N_CH-1:1];

  state_t          state_q;
  state_t          state_d;
  logic [ST_W-1:0] str_cnt_q;
  logic [ST_W-1:0] str_cnt_d;

  always_comb begin
    state_d   = state_q;
    str_cnt_d = str_cnt_q;
    if (!lock_sync || rst_btn_db) begin
      state_d   = HOLD;
      str_cnt_d = '0;
    end else begin
      case (state_q)
        HOLD: begin
          state_d   = STRETCH;
          str_cnt_d = '0;
        end
        STRETCH: begin
          if (str_cnt_q == ST_LAST) begin
            state_d = RUN;
          end else begin
            str_cnt_d = str_cnt_q + 1'b1;
          end
        end
        RUN:     state_d = RUN;
        default: state_d = HOLD;
      endcase
    end
  end

  // Outputs are flopped from the next state so they equal a decode of the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HOLD;
      str_cnt_q <= '0;
      sys_rst_o <= 1'b1;
      ready_o   <= 1'b0;
    end else begin
      state_q   <= state_d;
      str_cnt_q <= str_cnt_d;
      sys_rst_o <= (state_d != RUN);
      ready_o   <= (state_d == RUN);
    end
  end

  logic [N_BTN-1:0] btn_fire;
  logic [N_BTN-1:0] btn_new;
  assign btn_fire = fire[N_CH-1:1];
  assign btn_new  = sync[N_CH-1:1];

  // Gated with the next ready value so a pulse can never coexist with ready_o low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_press_o   <= '0;
      btn_release_o <= '0;
    end else if (state_d == RUN) begin
      btn_press_o   <= btn_fire & btn_new;
      btn_release_o <= btn_fire & ~btn_new;
    end else begin
      btn_press_o   <= '0;
      btn_release_o <= '0;
    end
  end

  logic [MR_W-1:0] mir_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mir_cnt  <= '0;
      mirror_o <= 1'b0;
    end else if (mir_cnt == MR_LAST) begin
      mir_cnt  <= '0;
      mirror_o <= ~mirror_o;
    end else begin
      mir_cnt <= mir_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_board_io_conditioner.sv
// Directed bench for board_io_conditioner: reset sequencing, debounce timing,
// pulse gating and clock mirror, with hand-derived edge-by-edge expectations.
module tb_board_io_conditioner;

  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         locked_i = 1'b0;
  logic         rst_btn_i = 1'b0;
  logic [N-1:0] btn_i = '0;

  logic         sys_rst_o, ready_o, mirror_o;
  logic [N-1:0] lvl, press, rel;
  logic         sys_rst_b, ready_b, mirror_b;
  logic [N-1:0] lvl_b, press_b, rel_b;

  int total = 0;
  int bad = 0;
  int ec;

  always #5 clk = ~clk;

  board_io_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(4), .RST_STRETCH(8), .MIRROR_HALF(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .locked_i(locked_i), .rst_btn_i(rst_btn_i), .btn_i(btn_i),
    .sys_rst_o(sys_rst_o), .ready_o(ready_o), .btn_level_o(lvl), .btn_press_o(press),
    .btn_release_o(rel), .mirror_o(mirror_o)
  );

  board_io_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(4), .RST_STRETCH(8), .MIRROR_HALF(1)
  ) dut_m1 (
    .clk(clk), .rst_n(rst_n), .locked_i(locked_i), .rst_btn_i(rst_btn_i), .btn_i(btn_i),
    .sys_rst_o(sys_rst_b), .ready_o(ready_b), .btn_level_o(lvl_b), .btn_press_o(press_b),
    .btn_release_o(rel_b), .mirror_o(mirror_b)
  );

  // Rising edges seen since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ec <= 0;
    else        ec <= ec + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic exp_rst, exp_m2, exp_m1;
    rst_n = 1'b0; locked_i = 1'b1; rst_btn_i = 1'b0; btn_i = '0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      total++; if (sys_rst_o !== 1'b1) begin bad++; $display("FAIL rst_sys_rst k=%0d got=%b exp=1", k, sys_rst_o); end
      total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready k=%0d got=%b exp=0", k, ready_o); end
      total++; if ({lvl, press, rel} !== 6'b0) begin bad++; $display("FAIL rst_btn_outs k=%0d got=%b exp=0", k, {lvl, press, rel}); end
      total++; if (mirror_o !== 1'b0) begin bad++; $display("FAIL rst_mirror k=%0d got=%b exp=0", k, mirror_o); end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      exp_rst = (k < 11);
      exp_m2  = ((k / 2) % 2) == 1;
      exp_m1  = (k % 2) == 1;
      total++; if (sys_rst_o !== exp_rst) begin bad++; $display("FAIL pwr_sys_rst k=%0d got=%b exp=%b", k, sys_rst_o, exp_rst); end
      total++; if (ready_o !== !exp_rst) begin bad++; $display("FAIL pwr_ready k=%0d got=%b exp=%b", k, ready_o, !exp_rst); end
      total++; if ({lvl, press, rel} !== 6'b0) begin bad++; $display("FAIL pwr_btn_outs k=%0d got=%b exp=0", k, {lvl, press, rel}); end
      total++; if (mirror_o !== exp_m2) begin bad++; $display("FAIL pwr_mirror2 k=%0d got=%b exp=%b", k, mirror_o, exp_m2); end
      total++; if (mirror_b !== exp_m1) begin bad++; $display("FAIL pwr_mirror1 k=%0d got=%b exp=%b", k, mirror_b, exp_m1); end
    end
  endtask

  task automatic test_debounce();
    btn_i[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      total++; if (lvl[0] !== (k >= 6)) begin bad++; $display("FAIL db_press_level k=%0d got=%b exp=%b", k, lvl[0], (k >= 6)); end
      total++; if (press[0] !== (k == 6)) begin bad++; $display("FAIL db_press_pulse k=%0d got=%b exp=%b", k, press[0], (k == 6)); end
      total++; if (rel[0] !== 1'b0) begin bad++; $display("FAIL db_press_rel k=%0d got=%b exp=0", k, rel[0]); end
      total++; if ({lvl[1], press[1], rel[1]} !== 3'b0) begin bad++; $display("FAIL db_press_ch1 k=%0d got=%b exp=0", k, {lvl[1], press[1], rel[1]}); end
    end
    btn_i[0] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      total++; if (lvl[0] !== (k < 6)) begin bad++; $display("FAIL db_rel_level k=%0d got=%b exp=%b", k, lvl[0], (k < 6)); end
      total++; if (rel[0] !== (k == 6)) begin bad++; $display("FAIL db_rel_pulse k=%0d got=%b exp=%b", k, rel[0], (k == 6)); end
      total++; if (press[0] !== 1'b0) begin bad++; $display("FAIL db_rel_press k=%0d got=%b exp=0", k, press[0]); end
    end
    btn_i[1] = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      if (k == 4) btn_i[1] = 1'b0;
      tick();
      total++; if ({lvl[1], press[1], rel[1]} !== 3'b0) begin bad++; $display("FAIL db_glitch k=%0d got=%b exp=0", k, {lvl[1], press[1], rel[1]}); end
    end
  endtask

  task automatic test_lock_loss();
    locked_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      total++; if (sys_rst_o !== (k >= 3)) begin bad++; $display("FAIL lock_drop_rst k=%0d got=%b exp=%b", k, sys_rst_o, (k >= 3)); end
      total++; if (ready_o !== (k < 3)) begin bad++; $display("FAIL lock_drop_ready k=%0d got=%b exp=%b", k, ready_o, (k < 3)); end
    end
    locked_i = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      total++; if (sys_rst_o !== (k < 11)) begin bad++; $display("FAIL relock_rst k=%0d got=%b exp=%b", k, sys_rst_o, (k < 11)); end
      total++; if (ready_o !== (k >= 11)) begin bad++; $display("FAIL relock_ready k=%0d got=%b exp=%b", k, ready_o, (k >= 11)); end
    end
  endtask

  task automatic test_rst_btn_mid_stretch();
    locked_i = 1'b0;
    repeat (4) tick();
    total++; if (sys_rst_o !== 1'b1) begin bad++; $display("FAIL rbtn_hold got=%b exp=1", sys_rst_o); end
    locked_i = 1'b1;
    // Debounced button lands while the stretch counter sits at 5.
    for (int k = 1; k <= 28; k++) begin
      if (k == 3)  rst_btn_i = 1'b1;
      if (k == 13) rst_btn_i = 1'b0;
      tick();
      total++; if (sys_rst_o !== (k < 27)) begin bad++; $display("FAIL rbtn_rst k=%0d got=%b exp=%b", k, sys_rst_o, (k < 27)); end
      total++; if (ready_o !== (k >= 27)) begin bad++; $display("FAIL rbtn_ready k=%0d got=%b exp=%b", k, ready_o, (k >= 27)); end
    end
  endtask

  task automatic test_pulse_gating();
    locked_i = 1'b0;
    btn_i[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      total++; if (sys_rst_o !== (k >= 3)) begin bad++; $display("FAIL gate_rst k=%0d got=%b exp=%b", k, sys_rst_o, (k >= 3)); end
      total++; if (lvl[0] !== (k >= 6)) begin bad++; $display("FAIL gate_level k=%0d got=%b exp=%b", k, lvl[0], (k >= 6)); end
      total++; if (press[0] !== 1'b0) begin bad++; $display("FAIL gate_press k=%0d got=%b exp=0", k, press[0]); end
    end
    locked_i = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      total++; if (sys_rst_o !== (k < 11)) begin bad++; $display("FAIL gate_relock_rst k=%0d got=%b exp=%b", k, sys_rst_o, (k < 11)); end
      total++; if (lvl[0] !== 1'b1) begin bad++; $display("FAIL gate_relock_level k=%0d got=%b exp=1", k, lvl[0]); end
      total++; if (press[0] !== 1'b0) begin bad++; $display("FAIL gate_late_press k=%0d got=%b exp=0", k, press[0]); end
    end
    btn_i[0] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      total++; if (rel[0] !== (k == 6)) begin bad++; $display("FAIL gate_rel_pulse k=%0d got=%b exp=%b", k, rel[0], (k == 6)); end
      total++; if (lvl[0] !== (k < 6)) begin bad++; $display("FAIL gate_rel_level k=%0d got=%b exp=%b", k, lvl[0], (k < 6)); end
    end
  endtask

  task automatic test_mirror();
    logic exp_m2, exp_m1;
    locked_i = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_m2 = ((ec / 2) % 2) == 1;
      exp_m1 = (ec % 2) == 1;
      total++; if (mirror_o !== exp_m2) begin bad++; $display("FAIL mirror_half2 k=%0d got=%b exp=%b", k, mirror_o, exp_m2); end
      total++; if (mirror_b !== exp_m1) begin bad++; $display("FAIL mirror_half1 k=%0d got=%b exp=%b", k, mirror_b, exp_m1); end
      if (k >= 3) begin
        total++; if (sys_rst_o !== 1'b1) begin bad++; $display("FAIL mirror_in_rst k=%0d got=%b exp=1", k, sys_rst_o); end
        total++; if ({sys_rst_b, ready_b, lvl_b, press_b, rel_b} !== 8'b1000_0000) begin
          bad++; $display("FAIL mirror_dut1_state k=%0d got=%b exp=10000000", k, {sys_rst_b, ready_b, lvl_b, press_b, rel_b});
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t limit=200000", $time);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_debounce();
    test_lock_loss();
    test_rst_btn_mid_stretch();
    test_pulse_gating();
    test_mirror();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/board_io_conditioner.md
Name: board_io_conditioner

Overview:
Parametrised board-level conditioning block between FPGA pins and the game core.
- Sequences the core reset from clock-wizard lock plus a debounced reset button.
- Debounces and synchronises N push-buttons, producing level, press and release outputs.
- Generates a divided clock-mirror output for bench observation on a PMOD pin.
- Sits in the FPGA top, in the pixel-clock domain (65 MHz), feeding the game core's active-high rst and button inputs.

Parameters:
N_BTN, 4, number of general push-button channels (>=1).
DEBOUNCE_CYCLES, 650000, stable-input cycles required before a debounced level changes (>=2; 10 ms at 65 MHz).
RST_STRETCH, 1024, cycles sys_rst_o stays high after lock and release conditions are met (>=1).
MIRROR_HALF, 1, mirror_o toggles every MIRROR_HALF cycles; output frequency is clk/(2*MIRROR_HALF) (>=1).

Ports:
clk  input  1  pixel clock (65 MHz); the only clock.
rst_n  input  1  asynchronous, active-low reset.
locked_i  input  1  clock-wizard locked; asynchronous to clk.
rst_btn_i  input  1  raw reset push-button, active-high; asynchronous.
btn_i  input  N_BTN  raw push-buttons, active-high; asynchronous.
sys_rst_o  output  1  synchronous active-high reset to the game core.
ready_o  output  1  high while in RUN state.
btn_level_o  output  N_BTN  debounced button levels.
btn_press_o  output  N_BTN  one-cycle pulse on a debounced 0->1 transition.
btn_release_o  output  N_BTN  one-cycle pulse on a debounced 1->0 transition.
mirror_o  output  1  divided clock mirror.

Behaviour:
Clock and reset:
- One clock domain. Reset is asynchronous and active-low, on rst_n.
- All flops reset asynchronously when rst_n=0.

Reset values:
- sys_rst_o=1.
- ready_o=0.
- btn_level_o, btn_press_o, btn_release_o = 0.
- mirror_o=0.
- All counters and synchroniser flops = 0.

Synchronisers:
- locked_i, rst_btn_i and each btn_i bit pass through a 2-FF synchroniser.

Debounce (identical per channel, including rst_btn):
- Per channel: a counter and a stable register.
- Synchronised value == stable: counter cleared.
- Otherwise the counter increments.
- When counter == DEBOUNCE_CYCLES-1 while still differing, on that edge: stable <= synchronised value, counter cleared.
- A single-cycle glitch shorter than DEBOUNCE_CYCLES never changes stable.
- Latency: a raw input held constant changes btn_level_o exactly DEBOUNCE_CYCLES+2 rising edges after first being sampled.

Press/release pulses:
- Registered, exactly 1 cycle, asserted on the same edge the level changes.
- Forced to 0 whenever ready_o=0, including while sys_rst_o=1.
- btn_level_o keeps tracking during reset.

Reset FSM (states HOLD, STRETCH, RUN):
- HOLD: sys_rst_o=1. Go to STRETCH when synced locked=1 and debounced rst_btn=0; clear the stretch counter.
- STRETCH: sys_rst_o=1, counter increments. Go to RUN when counter == RST_STRETCH-1.
- RUN: sys_rst_o=0, ready_o=1.
- From any state: synced locked=0 or debounced rst_btn=1 returns to HOLD on the next edge. This has priority over the stretch completion in the same cycle.
- sys_rst_o and ready_o are registered and decoded from the state register (sys_rst_o = state != RUN).
- Lock loss or button press mid-STRETCH restarts the full stretch after the condition clears.

Mirror:
- Free-running counter 0..MIRROR_HALF-1; mirror_o toggles when the counter wraps.
- Independent of the FSM; runs whenever rst_n=1.
- First toggle occurs MIRROR_HALF edges after reset release.

Widths:
- Counters are sized with $clog2 of (parameter+1).
- Parameters below their minimum are a synthesis-time error via assertion.

Test Plan:
Test parameters: N_BTN=2, DEBOUNCE_CYCLES=4, RST_STRETCH=8, MIRROR_HALF=2 unless stated.
1. Power-up: rst_n low 5 cycles, then high with locked_i=1, rst_btn_i=0 -> sys_rst_o=1 for 2(sync)+1(HOLD)+8 cycles, then 0 with ready_o=1; btn outputs all 0 throughout.
2. Debounce: btn_i[0] 0->1 held -> btn_level_o[0]=1 and btn_press_o[0] one-cycle pulse exactly 6 edges after the first sample; release gives the same timing with btn_release_o[0]. A 3-cycle pulse on btn_i[1] -> no level change, no pulse.
3. Lock loss: locked_i drops in RUN -> sys_rst_o=1 and ready_o=0 three edges later. Relock -> full 8-cycle stretch before RUN.
4. Reset button mid-STRETCH: rst_btn_i held high at stretch count 5 -> HOLD after debounce latency. Release -> stretch restarts from 0; total sys_rst_o high time verified.
5. Pulse gating: button press debounced while sys_rst_o=1 -> btn_level_o=1, btn_press_o stays 0, and no delayed pulse occurs after entering RUN.
6. Mirror: MIRROR_HALF=2 -> mirror_o period 4 cycles, 50% duty, first rise at edge 2 after rst_n release. MIRROR_HALF=1 -> toggles every cycle. Mirror continues during sys_rst_o=1.
